// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle control unit: FSM states, opcodes,
// ALU operation codes and datapath mux selects.
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC_R = 4'd6,
        S_ALU_WB = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_EXEC_I = 4'd10,
        S_IMM_WB = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_RTYPE = 2'b10;
    localparam logic [1:0] ALU_LOGIC = 2'b11;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // States that sit on the shared memory port waiting for mem_ready.
    function automatic logic is_mem_wait_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage

// File: rtl/ctrl_decode_op.sv
// Opcode decoder used in DECODE: picks the first execution state of the
// instruction and flags opcodes the datapath cannot execute.
// Optional macro CTRL_BNE_EN makes opcode 000101 (bne) a legal branch.
module ctrl_decode_op
    import ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    output state_t     next_state,
    output logic       legal
);

    // Pure lookup; illegal opcodes fall back to FETCH.
    always_comb begin
        next_state = S_FETCH;
        legal      = 1'b1;
        case (opcode)
            OP_RTYPE:                  next_state = S_EXEC_R;
            OP_LW, OP_SW:              next_state = S_MEMADR;
            OP_BEQ:                    next_state = S_BRANCH;
`ifdef CTRL_BNE_EN
            OP_BNE:                    next_state = S_BRANCH;
`endif
            OP_J:                      next_state = S_JUMP;
            OP_ADDI, OP_ANDI, OP_ORI:  next_state = S_EXEC_I;
            default: begin
                next_state = S_FETCH;
                legal      = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/control_multiciclo.sv
// Multicycle control FSM: sequences the shared memory port, ALU, IR and PC
// and drives every datapath mux/enable. Outputs are a function of the
// current state (plus mem_ready in FETCH, opcode in DECODE/EXEC_I and zero
// in BRANCH) and are forced low while reset is held.
// Optional macro CTRL_BNE_EN adds bne (opcode 000101) as a branch.
module control_multiciclo
    import ctrl_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic       ext_op,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       pc_en,
    output logic       illegal_op,
    output logic       mem_timeout,
    output logic [3:0] state
);

    localparam bit          WAIT_CHECK_EN = (MEM_WAIT_MAX > 0);
    localparam int unsigned WAIT_MAX_U    = MEM_WAIT_MAX;

    state_t     state_q, state_d;
    logic [3:0] wait_cnt_q, wait_cnt_d;
    logic       mem_timeout_q, mem_timeout_d;
    logic       in_wait;
    logic       branch_taken;
    state_t     dec_next_state;
    logic       dec_legal;

`ifdef CTRL_BNE_EN
    logic [5:0] op_latched_q, op_latched_d;
`endif

    // funct is decoded by the ALU control block, not by this FSM.
    logic unused_funct;
    assign unused_funct = ^funct;

    ctrl_decode_op u_decode (
        .opcode     (opcode),
        .next_state (dec_next_state),
        .legal      (dec_legal)
    );

    // Next-state sequencing; memory states hold until mem_ready.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  if (mem_ready) state_d = S_DECODE;
            S_DECODE: state_d = dec_next_state;
            S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWR:  if (mem_ready) state_d = S_FETCH;
            S_EXEC_R: state_d = S_ALU_WB;
            S_EXEC_I: state_d = S_IMM_WB;
            default:  state_d = S_FETCH;
        endcase
    end

    // Consecutive memory-wait counter (saturating) and sticky timeout flag.
    always_comb begin
        in_wait       = is_mem_wait_state(state_q) && !mem_ready;
        wait_cnt_d    = 4'd0;
        if (in_wait) begin
            wait_cnt_d = (wait_cnt_q == 4'hF) ? 4'hF : wait_cnt_q + 4'd1;
        end
        mem_timeout_d = mem_timeout_q;
        if (WAIT_CHECK_EN && in_wait && (32'(wait_cnt_d) >= WAIT_MAX_U)) begin
            mem_timeout_d = 1'b1;
        end
    end

`ifdef CTRL_BNE_EN
    // Capture the opcode as the instruction enters DECODE so BRANCH knows
    // whether the taken sense is inverted.
    always_comb begin
        op_latched_d = op_latched_q;
        if ((state_q == S_FETCH) && mem_ready) begin
            op_latched_d = opcode;
        end
    end
`endif

    // State, wait counter and timeout registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_FETCH;
            wait_cnt_q    <= 4'd0;
            mem_timeout_q <= 1'b0;
`ifdef CTRL_BNE_EN
            op_latched_q  <= 6'd0;
`endif
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
`ifdef CTRL_BNE_EN
            op_latched_q  <= op_latched_d;
`endif
        end
    end

    // Control word per state; everything is held low while reset is high so
    // an abandoned instruction cannot pulse a write enable.
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        ext_op        = 1'b0;
        alu_src_b     = SRCB_REG;
        alu_op        = ALU_ADD;
        pc_source     = PCSRC_ALU;
        illegal_op    = 1'b0;
        branch_taken  = zero;
`ifdef CTRL_BNE_EN
        if (op_latched_q == OP_BNE) branch_taken = ~zero;
`endif
        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = SRCB_FOUR;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                S_DECODE: begin
                    alu_src_b  = SRCB_IMM_SH2;
                    ext_op     = 1'b1;
                    illegal_op = ~dec_legal;
                end
                S_MEMADR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_IMM;
                    ext_op    = 1'b1;
                end
                S_MEMRD: begin
                    mem_read = 1'b1;
                    iord     = 1'b1;
                end
                S_MEMWB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end
                S_MEMWR: begin
                    mem_write = 1'b1;
                    iord      = 1'b1;
                end
                S_EXEC_R: begin
                    alu_src_a = 1'b1;
                    alu_op    = ALU_RTYPE;
                end
                S_ALU_WB: begin
                    reg_write = 1'b1;
                    reg_dst   = 1'b1;
                end
                S_EXEC_I: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_IMM;
                    if (opcode == OP_ADDI) begin
                        ext_op = 1'b1;
                        alu_op = ALU_ADD;
                    end else begin
                        ext_op = 1'b0;
                        alu_op = ALU_LOGIC;
                    end
                end
                S_IMM_WB: begin
                    reg_write = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a     = 1'b1;
                    alu_op        = ALU_SUB;
                    pc_write_cond = 1'b1;
                    pc_source     = PCSRC_ALUOUT;
                end
                S_JUMP: begin
                    pc_write  = 1'b1;
                    pc_source = PCSRC_JUMP;
                end
                default: begin
                    pc_write = 1'b0;
                end
            endcase
        end
    end

    assign pc_en       = pc_write | (pc_write_cond & branch_taken);
    assign mem_timeout = mem_timeout_q;
    assign state       = state_q;

endmodule

// File: tb/tb_control_multiciclo.sv
// Scoreboard bench for control_multiciclo. Each instruction is expanded into
// its sequence of phases; every driven cycle pushes the expected control
// word, and a negedge monitor pops and compares it with the DUT outputs.
module tb_control_multiciclo;

    localparam int WAIT_MAX = 2;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100, BNE = 6'b000101, JMP = 6'b000010;
    localparam logic [5:0] ADDI = 6'b001000, ANDI = 6'b001100, ORI = 6'b001101;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = 6'd0;
    logic [5:0] funct = 6'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, ext_op;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic       pc_en, illegal_op, mem_timeout;
    logic [3:0] state;

    logic [23:0] exp_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    bit          to_model = 1'b0;
    int          wait_run = 0;

    control_multiciclo #(.MEM_WAIT_MAX(WAIT_MAX)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
        .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .ext_op(ext_op), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .pc_source(pc_source), .pc_en(pc_en),
        .illegal_op(illegal_op), .mem_timeout(mem_timeout), .state(state)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    function automatic bit is_legal(input logic [5:0] op);
        case (op)
            RT, LW, SW, BEQ, JMP, ADDI, ANDI, ORI: return 1'b1;
`ifdef CTRL_BNE_EN
            BNE: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

    // Phase (state number) visited at step idx of an instruction, -1 = done.
    function automatic int phase_at(input logic [5:0] op, input int idx);
        int s[5];
        s = '{0, 1, -1, -1, -1};
        if (is_legal(op)) begin
            if (op == LW)                   s = '{0, 1, 2, 3, 4};
            else if (op == SW)              s = '{0, 1, 2, 5, -1};
            else if (op == RT)              s = '{0, 1, 6, 7, -1};
            else if (op == JMP)             s = '{0, 1, 9, -1, -1};
            else if (op == BEQ || op == BNE) s = '{0, 1, 8, -1, -1};
            else                            s = '{0, 1, 10, 11, -1};
        end
        return (idx < 5) ? s[idx] : -1;
    endfunction

    // Control word the datapath must see in a given phase.
    function automatic logic [23:0] exp_vec(input int ph, input logic [5:0] op,
                                            input logic mr, input logic z, input logic to);
        logic pw = 0, pwc = 0, io = 0, mrd = 0, mwr = 0, irw = 0, m2r = 0, rd = 0, rw = 0;
        logic sa = 0, ex = 0, pe = 0, ill = 0;
        logic [1:0] sb = 2'b00, ao = 2'b00, ps = 2'b00;
        case (ph)
            0: begin mrd = 1; sb = 2'b01; irw = mr; pw = mr; end
            1: begin sb = 2'b11; ex = 1; ill = !is_legal(op); end
            2: begin sa = 1; sb = 2'b10; ex = 1; end
            3: begin mrd = 1; io = 1; end
            4: begin rw = 1; m2r = 1; end
            5: begin mwr = 1; io = 1; end
            6: begin sa = 1; ao = 2'b10; end
            7: begin rw = 1; rd = 1; end
            8: begin sa = 1; ao = 2'b01; pwc = 1; ps = 2'b01; pe = (op == BNE) ? !z : z; end
            9: begin pw = 1; ps = 2'b10; end
            10: begin sa = 1; sb = 2'b10; ex = (op == ADDI); ao = (op == ADDI) ? 2'b00 : 2'b11; end
            11: begin rw = 1; end
            default: ;
        endcase
        pe = pe | pw;
        return {4'(ph), pw, pwc, io, mrd, mwr, irw, m2r, rd, rw, sa, ex, sb, ao, ps, pe, ill, to};
    endfunction

    task automatic one_cycle(input int ph, input logic [5:0] op, input logic mr, input logic z);
        reset = 1'b0;
        opcode = op;
        funct = 6'($urandom);
        mem_ready = mr;
        zero = z;
        exp_q.push_back(exp_vec(ph, op, mr, z, to_model));
        if ((ph == 0 || ph == 3 || ph == 5) && !mr) begin
            wait_run++;
            if (wait_run >= WAIT_MAX) to_model = 1'b1;
        end else begin
            wait_run = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic reset_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            reset = 1'b1;
            mem_ready = 1'($urandom);
            zero = 1'($urandom);
            to_model = 1'b0;
            wait_run = 0;
            exp_q.push_back(24'h0);
            @(posedge clk);
            #1;
        end
        $display("reset %0d cycle(s)", n);
    endtask

    // fetch_waits < 0 : random; zero_force < 0 : random zero each cycle.
    task automatic run_instr(input logic [5:0] op, input int fetch_waits,
                             input bit rand_waits, input int zero_force);
        int idx = 0;
        int ph, k, cyc = 0;
        logic z;
        forever begin
            ph = phase_at(op, idx);
            if (ph < 0) break;
            if (ph == 0 || ph == 3 || ph == 5) begin
                if (ph == 0 && fetch_waits >= 0) k = fetch_waits;
                else if (rand_waits && $urandom_range(0, 3) == 0) k = $urandom_range(1, 3);
                else k = 0;
                for (int w = 0; w <= k; w++) begin
                    z = (zero_force < 0) ? 1'($urandom) : zero_force[0];
                    one_cycle(ph, op, (w == k), z);
                    cyc++;
                end
            end else begin
                z = (zero_force < 0) ? 1'($urandom) : zero_force[0];
                one_cycle(ph, op, 1'($urandom), z);
                cyc++;
            end
            idx++;
        end
        $display("instr op=%b cycles=%0d timeout_exp=%0b", op, cyc, to_model);
    endtask

    // Monitor: compare every cycle that has an expectation queued.
    initial begin
        logic [23:0] e, a;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {state, pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
                     mem_to_reg, reg_dst, reg_write, alu_src_a, ext_op, alu_src_b, alu_op,
                     pc_source, pc_en, illegal_op, mem_timeout};
                n_cmp++;
                if (a !== e) begin
                    n_err++;
                    $display("FAIL ctrl_word t=%0t state=%0d got=%h expected=%h", $time, state, a, e);
                end
            end
        end
    end

    initial begin
        logic [5:0] ops[10];
        logic [5:0] op;
        ops = '{LW, SW, RT, BEQ, BNE, JMP, ADDI, ANDI, ORI, LW};
        repeat (2) @(posedge clk);
        #1;
        reset_cycles(2);
        // lw with memory always ready: 0,1,2,3,4 then back to FETCH
        run_instr(LW, 0, 1'b0, -1);
        // beq taken / not taken
        run_instr(BEQ, 0, 1'b0, 1);
        run_instr(BEQ, 0, 1'b0, 0);
        // immediate variants
        run_instr(ANDI, 0, 1'b0, -1);
        run_instr(ADDI, 0, 1'b0, -1);
        run_instr(ORI, 0, 1'b0, -1);
        run_instr(SW, 0, 1'b0, -1);
        run_instr(RT, 0, 1'b0, -1);
        run_instr(JMP, 0, 1'b0, -1);
        // undecoded opcode
        run_instr(6'b111111, 0, 1'b0, -1);
        // three fetch waits: timeout sets after the second
        run_instr(RT, 3, 1'b0, -1);
        // reset in the middle of a stalled MEMRD
        reset_cycles(1);
        one_cycle(0, LW, 1'b1, 1'b0);
        one_cycle(1, LW, 1'b1, 1'b0);
        one_cycle(2, LW, 1'b1, 1'b0);
        one_cycle(3, LW, 1'b0, 1'b0);
        reset_cycles(1);
        run_instr(LW, 0, 1'b0, -1);
        // randomized instruction stream
        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 9) == 0) reset_cycles($urandom_range(1, 2));
            if ($urandom_range(0, 7) == 0) op = 6'($urandom);
            else op = ops[$urandom_range(0, 9)];
            run_instr(op, -1, 1'b1, -1);
        end
        repeat (2) @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/control_multiciclo.md
Name: control_multiciclo

Overview:
- Moore-style FSM that turns the single-cycle datapath into a multicycle one by sequencing one shared memory port, one ALU, the IR and the PC.
- Drives every datapath mux and enable, including ext_op, which selects sign or zero extension of the 16-bit immediate.
- Sits between the instruction register (opcode/funct) and the datapath. Waits on a memory ready handshake.

Parameters:
- MEM_WAIT_MAX, 15, memory-wait cycles tolerated before mem_timeout is flagged; 0 disables the check.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- opcode  in  6  IR[31:26]
- funct  in  6  IR[5:0]; passed through for the ALU decoder, unused by the FSM
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completed current read/write this cycle
- pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write  out  1 each
- mem_to_reg, reg_dst, reg_write, alu_src_a, ext_op  out  1 each
- alu_src_b  out  2  00 reg B, 01 constant 4, 10 extended imm, 11 extended imm<<2
- alu_op  out  2  00 add, 01 sub, 10 R-type (funct), 11 logic-imm
- pc_source  out  2  00 ALU, 01 ALUOut, 10 jump target
- pc_en  out  1  = pc_write | (pc_write_cond & branch_taken)
- illegal_op  out  1  one-cycle pulse on an undecoded opcode
- mem_timeout  out  1  sticky until reset
- state  out  4  current state, for debug

Behaviour:
- Reset:
  - Async assert forces state=FETCH and clears mem_timeout and the wait counter.
  - While reset=1, all control outputs are 0, including mem_read.
  - Reset mid-operation abandons the instruction; no write enable may glitch high.
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC_R=6, ALU_WB=7, BRANCH=8, JUMP=9, EXEC_I=10, IMM_WB=11.
- FETCH:
  - mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - ir_write and pc_write are asserted only in the cycle mem_ready=1; that cycle moves to DECODE.
  - Otherwise stay in FETCH.
- DECODE: alu_src_a=0, alu_src_b=11, ext_op=1 (branch target precompute). Next state by opcode:
  - 000000 -> EXEC_R
  - 100011 (lw) or 101011 (sw) -> MEMADR
  - 000100 (beq) -> BRANCH
  - 000010 (j) -> JUMP
  - 001000 (addi), 001100 (andi), 001101 (ori) -> EXEC_I
  - any other opcode -> FETCH, with illegal_op=1 for that cycle
- MEMADR: alu_src_a=1, alu_src_b=10, ext_op=1, alu_op=00. lw -> MEMRD, sw -> MEMWR.
- MEMRD: mem_read=1, iord=1. Hold until mem_ready, then go to MEMWB.
- MEMWR: mem_write=1, iord=1. Hold until mem_ready, then go to FETCH.
- MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0 -> FETCH.
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=10 -> ALU_WB.
- ALU_WB: reg_write=1, reg_dst=1, mem_to_reg=0 -> FETCH.
- EXEC_I:
  - alu_src_a=1, alu_src_b=10.
  - addi: ext_op=1, alu_op=00.
  - andi/ori: ext_op=0, alu_op=11.
  - Next state IMM_WB.
- IMM_WB: reg_write=1, reg_dst=0, mem_to_reg=0 -> FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01, branch_taken=zero -> FETCH.
- JUMP: pc_write=1, pc_source=10 -> FETCH.
- Cycle counts (mem_ready=1 immediately): lw 5, sw 4, R-type 4, addi/andi/ori 4, beq 3, j 3.
- Memory-wait counter:
  - 4 bits; counts consecutive cycles in FETCH/MEMRD/MEMWR with mem_ready=0.
  - Clears on mem_ready=1 or on a state change.
  - When the count reaches MEM_WAIT_MAX, mem_timeout is set. The FSM keeps waiting; there is no forced abort.
  - The counter saturates at 15.
- Unlisted outputs in each state are 0.
- mem_read and mem_write are never both 1 in the same cycle.

Optional Feature:
- Macro CTRL_BNE_EN.
- Defined:
  - opcode 000101 (bne) decodes to BRANCH.
  - In BRANCH, branch_taken = ~zero when the latched opcode is bne.
  - The opcode is latched at the FETCH->DECODE transition.
- Undefined: 000101 is illegal (illegal_op pulse, return to FETCH).

Decomposition:
- Package ctrl_pkg holds:
  - state encodings;
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_ADDI, OP_ANDI, OP_ORI);
  - alu_op codes;
  - alu_src_b and pc_source encodings.
- One sub-module, ctrl_decode_op: combinational opcode -> next-state/legal decoder used in DECODE.
- State register, wait counter and output logic stay in the top module.

Test Plan:
- Reset asserted mid-MEMRD -> same cycle all outputs 0, state=0; after release, FETCH with mem_read=1.
- lw (opcode 100011), mem_ready held 1 -> state sequence 0,1,2,3,4,0; reg_write=1 and mem_to_reg=1 only in state 4; 5 cycles.
- Fetch with mem_ready low 3 cycles, MEM_WAIT_MAX=2 -> ir_write=0 for the first 3 cycles, mem_timeout sets after 2 waits, ir_write/pc_write=1 on cycle 4.
- beq with zero=1 -> pc_en=1 in BRANCH; with zero=0 -> pc_en=0; both return to FETCH after 3 cycles.
- andi (001100) -> ext_op=0 and alu_op=11 in EXEC_I; addi (001000) -> ext_op=1, alu_op=00.
- Opcode 111111 -> illegal_op one-cycle pulse in DECODE, next state FETCH, no write enable asserted.
